render_frame_scheduler: RTL

RENDER_FRAME_SCHEDULER -- requirements
Module: render_frame_scheduler

---
 rtl/render_frame_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/render_frame_scheduler.sv
// Render frame scheduler: sequences one frame as clear -> per-model render
// handshakes -> wait for vsync -> buffer swap.
// Ports:
//   clk, rstn        clock and async active-low reset
//   i_frame_start    request one frame (accepted only in IDLE without abort)
//   i_abort          abandon the current frame (ignored in IDLE)
//   i_model_count    models in the frame, latched at accepted frame start
//   i_vsync          display vertical sync
//   i_rp_ready       render pipeline ready for a start pulse
//   i_rp_finished    render pipeline finished the current model
//   o_rp_start       one-cycle render start pulse
//   o_model_idx      index of the model being rendered
//   o_clear_en       clear write enable
//   o_clear_addr     clear write address
//   o_fb_swap        one-cycle front/back buffer swap
//   o_frame_done     one-cycle frame complete, coincident with o_fb_swap
//   o_busy           high outside IDLE
//   o_overrun        one-cycle pulse after a frame start seen while busy
module render_frame_scheduler #(
  parameter int unsigned SCREEN_WIDTH   = 320,
  parameter int unsigned SCREEN_HEIGHT  = 320,
  parameter int unsigned ADDRWIDTH      = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  parameter int unsigned MODEL_IDXWIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_frame_start,
  input  logic                      i_abort,
  input  logic [MODEL_IDXWIDTH-1:0] i_model_count,
  input  logic                      i_vsync,
  input  logic                      i_rp_ready,
  input  logic                      i_rp_finished,
  output logic                      o_rp_start,
  output logic [MODEL_IDXWIDTH-1:0] o_model_idx,
  output logic                      o_clear_en,
  output logic [ADDRWIDTH-1:0]      o_clear_addr,
  output logic                      o_fb_swap,
  output logic                      o_frame_done,
  output logic                      o_busy,
  output logic                      o_overrun
);

  localparam int unsigned NUM_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_READY,
    START,
    WAIT_FINISH,
    WAIT_VSYNC,
    SWAP
  } state_e;

  state_e                    state_q, state_d;
  logic [MODEL_IDXWIDTH-1:0] count_q, count_d;
  logic [MODEL_IDXWIDTH-1:0] idx_q, idx_d;
  logic [ADDRWIDTH-1:0]      addr_q, addr_d;
  logic                      clear_en_q, clear_en_d;
  logic                      rp_start_q, rp_start_d;
  logic                      swap_q, swap_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      clear_en_q <= 1'b0;
      rp_start_q <= 1'b0;
      swap_q     <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      clear_en_q <= clear_en_d;
      rp_start_q <= rp_start_d;
      swap_q     <= swap_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic; output flops are loaded from the next state so they
  // line up exactly with the state they describe.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;

    case (state_q)
      IDLE: begin
        if (i_frame_start && !i_abort) begin
          state_d = CLEAR;
          count_d = i_model_count;
          idx_d   = '0;
          addr_d  = '0;
        end
      end
      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = (count_q != '0) ? WAIT_READY : WAIT_VSYNC;
        end else begin
          addr_d = addr_q + ADDRWIDTH'(1);
        end
      end
      WAIT_READY: begin
        if (i_rp_ready) state_d = START;
      end
      START: begin
        state_d = WAIT_FINISH;
      end
      WAIT_FINISH: begin
        if (i_rp_finished) begin
          if (idx_q == count_q - MODEL_IDXWIDTH'(1)) begin
            state_d = WAIT_VSYNC;
          end else begin
            idx_d   = idx_q + MODEL_IDXWIDTH'(1);
            state_d = WAIT_READY;
          end
        end
      end
      WAIT_VSYNC: begin
        if (i_vsync) state_d = SWAP;
      end
      SWAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every other transition outside IDLE
    if (i_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = '0;
    end

    clear_en_d = (state_d == CLEAR);
    rp_start_d = (state_d == START);
    swap_d     = (state_d == SWAP);
    busy_d     = (state_d != IDLE);
    overrun_d  = i_frame_start && (state_q != IDLE);
  end

  assign o_rp_start   = rp_start_q;
  assign o_model_idx  = idx_q;
  assign o_clear_en   = clear_en_q;
  assign o_clear_addr = addr_q;
  assign o_fb_swap    = swap_q;
  assign o_frame_done = swap_q;
  assign o_busy       = busy_q;
  assign o_overrun    = overrun_q;

endmodule
